imm_gen_stage: RTL

Registered, parametrised immediate-generation pipeline stage between fetch and decode/execute.
- Accepts one 32-bit RV instruction per cycle over a valid/ready handshake.
- Produces the sign- or zero-extended XLEN-bit immediate, an immediate-format code and the pass-through instruction.
- A 2-entry skid buffer gives full throughput with a registered ready, so no combinational ready path runs back to fetch.

---
 rtl/imm_gen_stage.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_stage.sv
//------------------------------------------------------------------------------
// Module  : imm_gen_stage
// Purpose : Registered RV immediate-generation stage with a 2-entry skid buffer.
//           Optional CSR uimm decode is enabled by defining IMMGEN_ZICSR_EN.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_gen_stage #(
    parameter int XLEN       = 32,
    parameter bit PASS_INSTR = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_imm_type,
    output logic [31:0]     o_instr
);

    localparam logic [2:0] TYPE_I = 3'd0;
    localparam logic [2:0] TYPE_S = 3'd1;
    localparam logic [2:0] TYPE_B = 3'd2;
    localparam logic [2:0] TYPE_U = 3'd3;
    localparam logic [2:0] TYPE_J = 3'd4;
`ifdef IMMGEN_ZICSR_EN
    localparam logic [2:0] TYPE_Z = 3'd5;
`endif

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ready_q;

    logic [31:0]     w_imm32;
    logic [63:0]     w_imm64;
    logic [XLEN-1:0] w_imm;
    logic [2:0]      w_type;

    logic [XLEN-1:0] out_imm_q, skd_imm_q;
    logic [2:0]      out_type_q, skd_type_q;

    logic w_accept, w_release;
    logic w_ld_out_new, w_ld_out_skd, w_clr_out, w_ld_skd, w_clr_skd;

    // Decode as a 32-bit value; bit 31 is the sign for every format.
    always_comb begin
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
        w_type  = TYPE_I;
        case (i_instr[6:0])
            7'b0110111, 7'b0010111: begin
                w_imm32 = {i_instr[31:12], 12'b0};
                w_type  = TYPE_U;
            end
            7'b0100011: begin
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                w_type  = TYPE_S;
            end
            7'b1100011: begin
                w_imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
                w_type  = TYPE_B;
            end
            7'b1101111: begin
                w_imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
                w_type  = TYPE_J;
            end
`ifdef IMMGEN_ZICSR_EN
            7'b1110011: begin
                if (i_instr[14]) begin
                    w_imm32 = {27'b0, i_instr[19:15]};
                    w_type  = TYPE_Z;
                end
            end
`endif
            default: ;
        endcase
    end

    assign w_imm64 = {{32{w_imm32[31]}}, w_imm32};
    assign w_imm   = w_imm64[XLEN-1:0];

    assign o_valid   = (state_q != ST_EMPTY);
    assign o_ready   = ready_q;
    assign w_accept  = i_valid & ready_q;
    assign w_release = o_valid & i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
        end
    end

    always_comb begin
        state_d      = state_q;
        w_ld_out_new = 1'b0;
        w_ld_out_skd = 1'b0;
        w_clr_out    = 1'b0;
        w_ld_skd     = 1'b0;
        w_clr_skd    = 1'b0;
        if (i_flush) begin
            state_d   = ST_EMPTY;
            w_clr_out = 1'b1;
            w_clr_skd = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d      = ST_ONE;
                        w_ld_out_new = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_release) begin
                        w_ld_out_new = 1'b1;
                    end else if (w_accept) begin
                        state_d  = ST_FULL;
                        w_ld_skd = 1'b1;
                    end else if (w_release) begin
                        state_d   = ST_EMPTY;
                        w_clr_out = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_release) begin
                        state_d      = ST_ONE;
                        w_ld_out_skd = 1'b1;
                        w_clr_skd    = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_EMPTY;
                    w_clr_out = 1'b1;
                    w_clr_skd = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_imm_q  <= '0;
            out_type_q <= '0;
            skd_imm_q  <= '0;
            skd_type_q <= '0;
        end else begin
            if (w_clr_out) begin
                out_imm_q  <= '0;
                out_type_q <= '0;
            end else if (w_ld_out_new) begin
                out_imm_q  <= w_imm;
                out_type_q <= w_type;
            end else if (w_ld_out_skd) begin
                out_imm_q  <= skd_imm_q;
                out_type_q <= skd_type_q;
            end
            if (w_clr_skd) begin
                skd_imm_q  <= '0;
                skd_type_q <= '0;
            end else if (w_ld_skd) begin
                skd_imm_q  <= w_imm;
                skd_type_q <= w_type;
            end
        end
    end

    assign o_imm      = out_imm_q;
    assign o_imm_type = out_type_q;

    generate
        if (PASS_INSTR) begin : g_pass_instr
            logic [31:0] out_instr_q, skd_instr_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    out_instr_q <= '0;
                    skd_instr_q <= '0;
                end else begin
                    if (w_clr_out)         out_instr_q <= '0;
                    else if (w_ld_out_new) out_instr_q <= i_instr;
                    else if (w_ld_out_skd) out_instr_q <= skd_instr_q;
                    if (w_clr_skd)         skd_instr_q <= '0;
                    else if (w_ld_skd)     skd_instr_q <= i_instr;
                end
            end

            assign o_instr = out_instr_q;
        end else begin : g_no_instr
            assign o_instr = '0;
        end
    endgenerate

endmodule

`default_nettype wire
